// File: rtl/pbch_demapper.sv
// PBCH QPSK demapper: strips guard, DMRS and SSS REs from three equalized
// PBCH symbols and emits 432 soft LLR pairs per SSB with tlast on the last.
module pbch_demapper #(
  parameter int IN_DW  = 32,
  parameter int LLR_DW = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [IN_DW-1:0]      s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  input  logic [9:0]            N_id_i,
  input  logic                  N_id_valid_i,
  input  logic                  PBCH_start_i,
  output logic [2*LLR_DW-1:0]   m_axis_out_tdata,
  output logic                  m_axis_out_tvalid,
  output logic                  m_axis_out_tlast
);

  localparam int HALF  = IN_DW / 2;
  localparam int SHIFT = HALF - LLR_DW;

  typedef enum logic [1:0] {IDLE, SYM0, SYM1, SYM2} state_t;

  state_t              state_reg, state_next;
  logic [9:0]          n_id_reg;
  logic [1:0]          v_reg;
  logic [7:0]          k_reg;
  logic [8:0]          cnt_reg;
  logic [2*LLR_DW-1:0] tdata_reg;
  logic                tvalid_reg;
  logic                tlast_reg;

  logic                start_accept;
  logic                sym_end;
  logic [7:0]          s_idx;
  logic                in_band;
  logic                dmrs;
  logic                pbch_region;
  logic                data_re;
  logic signed [HALF-1:0] re_s, im_s, re_sh, im_sh;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    sym_end      = (state_reg != IDLE) && s_axis_in_tvalid && (k_reg == 8'd255);
    case (state_reg)
      IDLE: if (PBCH_start_i) begin
        start_accept = 1'b1;
        state_next   = SYM0;
      end
      SYM0: if (sym_end) state_next = SYM1;
      SYM1: if (sym_end) state_next = SYM2;
      SYM2: if (sym_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // s = k - 8; SYM1 keeps only s <= 47 or s >= 192 (k <= 55 or k >= 200)
  always_comb begin
    s_idx       = k_reg - 8'd8;
    in_band     = (k_reg >= 8'd8) && (k_reg <= 8'd247);
    dmrs        = (s_idx[1:0] == v_reg);
    pbch_region = (state_reg == SYM1) ? ((k_reg <= 8'd55) || (k_reg >= 8'd200)) : 1'b1;
    data_re     = s_axis_in_tvalid && (state_reg != IDLE) && in_band && !dmrs && pbch_region;
  end

  always_comb begin
    re_s  = s_axis_in_tdata[HALF-1:0];
    im_s  = s_axis_in_tdata[IN_DW-1:HALF];
    re_sh = re_s >>> SHIFT;
    im_sh = im_s >>> SHIFT;
  end

  logic unused_bits;
  assign unused_bits = ^{re_sh[HALF-1:LLR_DW], im_sh[HALF-1:LLR_DW], n_id_reg[9:2], s_idx[7:2]};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      n_id_reg   <= '0;
      v_reg      <= '0;
      k_reg      <= '0;
      cnt_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
    end else begin
      if (N_id_valid_i) n_id_reg <= N_id_i;
      if (start_accept) begin
        v_reg   <= n_id_reg[1:0];
        k_reg   <= '0;
        cnt_reg <= '0;
      end else if ((state_reg != IDLE) && s_axis_in_tvalid) begin
        // 8-bit wrap from 255 to 0 doubles as the symbol-boundary reset
        k_reg <= k_reg + 8'd1;
      end
      tvalid_reg <= data_re;
      tlast_reg  <= data_re && (cnt_reg == 9'd431);
      if (data_re) begin
        tdata_reg <= {im_sh[LLR_DW-1:0], re_sh[LLR_DW-1:0]};
        cnt_reg   <= cnt_reg + 9'd1;
      end
    end
  end

  assign m_axis_out_tdata  = tdata_reg;
  assign m_axis_out_tvalid = tvalid_reg;
  assign m_axis_out_tlast  = tlast_reg;

endmodule
